// File: rtl/dpram_port_b_master_if.sv
// Port B bus of the shared dual-port RAM. The master issues reads and writes;
// the slave (the RAM) returns read data one cycle after a read enable.
interface dpram_port_b_master_if #(
    parameter int unsigned data_width_g = 8,
    parameter int unsigned addr_width_g = 14
);
    logic                    ram_cs_b;
    logic                    ram_we_b;
    logic [addr_width_g-1:0] ram_ad_b;
    logic [data_width_g-1:0] ram_d_b;
    logic [data_width_g-1:0] ram_q_b;

    modport master (
        output ram_cs_b,
        output ram_we_b,
        output ram_ad_b,
        output ram_d_b,
        input  ram_q_b
    );

    modport slave (
        input  ram_cs_b,
        input  ram_we_b,
        input  ram_ad_b,
        input  ram_d_b,
        output ram_q_b
    );
endinterface

// File: rtl/dpram_port_b_master.sv
// Port B initiator for the shared dual-port RAM: accepts HPS download writes,
// fills the whole RAM with a constant, or reads back a region and reports a
// 16-bit additive checksum. All outputs are registered.
module dpram_port_b_master #(
    parameter int unsigned data_width_g = 8,
    parameter int unsigned addr_width_g = 14
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    dl_active,
    input  logic                    dl_wr,
    input  logic [addr_width_g-1:0] dl_addr,
    input  logic [data_width_g-1:0] dl_data,
    output logic                    dl_wait,
    input  logic                    start_clear,
    input  logic [data_width_g-1:0] fill_value,
    input  logic                    start_sum,
    input  logic [addr_width_g:0]   sum_len,
    output logic [15:0]             sum,
    output logic                    busy,
    output logic                    done,
    dpram_port_b_master_if.master   ram_b
);

    // Only the low 16 bits of a RAM word contribute to the checksum.
    localparam int unsigned q_width = (data_width_g < 16) ? data_width_g : 16;
    localparam logic [addr_width_g:0] last_addr = {1'b0, {addr_width_g{1'b1}}};

    typedef enum logic [2:0] {StIdle, StClear, StSumRd, StSumLast, StFinish} state_t;

    state_t                  state_q;
    logic [addr_width_g:0]   cnt_q;      // one bit wider so a full-depth job ends cleanly
    logic [addr_width_g:0]   len_q;
    logic [data_width_g-1:0] fill_q;
    logic                    is_sum_q;
    logic [15:0]             acc_q;
    logic                    q_valid_q;  // ram_q_b holds data for a read issued last cycle
    logic                    cs_q;
    logic                    we_q;
    logic [addr_width_g-1:0] ad_q;
    logic [data_width_g-1:0] d_q;
    logic [15:0]             q16;

    assign ram_b.ram_cs_b = cs_q;
    assign ram_b.ram_we_b = we_q;
    assign ram_b.ram_ad_b = ad_q;
    assign ram_b.ram_d_b  = d_q;

    // Zero-extend or truncate the read datum to the checksum width.
    always_comb begin
        q16 = '0;
        q16[q_width-1:0] = ram_b.ram_q_b[q_width-1:0];
    end

    // Job sequencer with registered bus and status outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            fill_q    <= '0;
            is_sum_q  <= 1'b0;
            acc_q     <= '0;
            q_valid_q <= 1'b0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            ad_q      <= '0;
            d_q       <= '0;
            sum       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dl_wait   <= 1'b0;
        end else begin
            done      <= 1'b0;
            q_valid_q <= cs_q;
            if (q_valid_q) begin
                acc_q <= acc_q + q16;
            end
            unique case (state_q)
                StIdle: begin
                    cs_q <= 1'b0;
                    we_q <= dl_wr && !dl_wait;
                    if (dl_wr && !dl_wait) begin
                        ad_q <= dl_addr;
                        d_q  <= dl_data;
                    end
                    if (!dl_active && !busy) begin
                        if (start_clear) begin
                            state_q  <= StClear;
                            busy     <= 1'b1;
                            dl_wait  <= 1'b1;
                            cnt_q    <= '0;
                            fill_q   <= fill_value;
                            is_sum_q <= 1'b0;
                        end else if (start_sum) begin
                            state_q  <= (sum_len == '0) ? StFinish : StSumRd;
                            busy     <= 1'b1;
                            dl_wait  <= 1'b1;
                            cnt_q    <= '0;
                            len_q    <= sum_len;
                            acc_q    <= '0;
                            is_sum_q <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    cs_q  <= 1'b0;
                    we_q  <= 1'b1;
                    ad_q  <= cnt_q[addr_width_g-1:0];
                    d_q   <= fill_q;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == last_addr) begin
                        state_q <= StFinish;
                    end
                end
                StSumRd: begin
                    cs_q  <= 1'b1;
                    we_q  <= 1'b0;
                    ad_q  <= cnt_q[addr_width_g-1:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_q <= StSumLast;
                    end
                end
                StSumLast: begin
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= StFinish;
                end
                StFinish: begin
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    dl_wait <= 1'b0;
                    // The last read datum arrives on this edge, so fold it in directly.
                    if (is_sum_q) begin
                        sum <= acc_q + (q_valid_q ? q16 : 16'd0);
                    end
                    state_q <= StIdle;
                end
                default: begin
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/dpram_port_b_master.md
Name: dpram_port_b_master

Overview:
- Initiator for port B of the shared dual-port RAM (`dpram`). Port B is the loader/maintenance side; port A stays with the CPU/video.
- Performs three jobs, one at a time:
  - writes HPS cartridge-download bytes into RAM;
  - clears or fills the whole RAM with a constant;
  - reads back a region and reports a 16-bit additive checksum, so firmware can confirm a cart image loaded correctly.
- Sits between the HPS ioctl download interface and `dpram`, in the `clk_sys` domain.

Parameters:
- data_width_g, 8: RAM word width. Must match `dpram`.
- addr_width_g, 14: RAM address width. RAM depth is 2**addr_width_g.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  HPS download in progress.
- dl_wr  in  1  one-cycle strobe: a download word is valid.
- dl_addr  in  addr_width_g  download word address.
- dl_data  in  data_width_g  download word.
- dl_wait  out  1  stall request to the HPS. dl_wr is accepted only while dl_wait=0.
- start_clear  in  1  pulse: fill the entire RAM with fill_value.
- fill_value  in  data_width_g  fill constant, sampled on the start_clear accept cycle.
- start_sum  in  1  pulse: checksum words 0..sum_len-1.
- sum_len  in  addr_width_g+1  number of words to sum, 0..2**addr_width_g. Sampled on accept.
- sum  out  16  checksum result. Held until the next sum job is accepted.
- busy  out  1  a clear or sum job is in progress.
- done  out  1  one-cycle pulse when a clear or sum job completes.
- ram_cs_b  out  1  port B read enable.
- ram_we_b  out  1  port B write enable.
- ram_ad_b  out  addr_width_g  port B address.
- ram_d_b  out  data_width_g  port B write data.
- ram_q_b  in  data_width_g  port B read data, valid one cycle after ram_cs_b.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, including sum=0 and dl_wait=0. State=IDLE.
- Reset asserted mid-job aborts the job immediately. No done pulse is produced.

States: IDLE, CLEAR, SUM_RD, SUM_LAST, FINISH.

IDLE:
- dl_wr=1 with dl_wait=0: on the next cycle drive ram_we_b=1, ram_cs_b=0, ram_ad_b=dl_addr, ram_d_b=dl_data. Write latency is 1 cycle.
- Back-to-back dl_wr is supported at one word per cycle.
- start_clear and start_sum are ignored while dl_active=1 or busy=1.
- If both starts arrive in the same cycle, clear wins and start_sum is dropped.

CLEAR:
- Write fill_value to addresses 0..2**addr_width_g-1 in ascending order, one per cycle, with ram_we_b=1.
- Total of 2**addr_width_g write cycles, then go to FINISH.

SUM_RD:
- Issue ram_cs_b=1, ram_we_b=0 for addresses 0..sum_len-1, one per cycle.
- The accumulator adds ram_q_b one cycle after each read. Add zero-extended to 16 bits if data_width_g<16; add the low 16 bits if wider.
- The accumulator wraps modulo 2**16 and starts at 0.
- After the last address is issued, go to SUM_LAST.

SUM_LAST:
- Absorb the final read datum, then go to FINISH.

sum_len=0:
- Go directly from accept to FINISH with sum=0. No RAM access.

FINISH:
- Load sum (sum jobs only). Pulse done=1 for one cycle. Return to IDLE.

busy:
- Goes to 1 on the cycle after a job is accepted.
- Returns to 0 in the same cycle that done=1.

Port-B cycle counts:
- CLEAR: busy=1 for 2**addr_width_g+1 cycles.
- SUM with sum_len=N>0: busy=1 for N+2 cycles.

dl_wait:
- dl_wait=1 whenever busy=1.
- dl_wr strobes while dl_wait=1 are dropped, not queued. The HPS must honour dl_wait.

Between operations:
- ram_cs_b=0 and ram_we_b=0 whenever no operation is issuing.
- ram_we_b and ram_cs_b are never both 1.

Address counter:
- addr_width_g+1 bits wide, so a full-depth job terminates without wrap-around ambiguity.

Test Plan (addr_width_g=4, data_width_g=8 unless noted):
1. Reset mid-CLEAR:
   - Stimulus: assert reset_n=0 at clear address 5.
   - Required: all outputs 0 on the same edge (asynchronous), no done pulse, state IDLE after release.
2. Download:
   - Stimulus: dl_wr back-to-back at addresses 0..3 with data 0x11,0x22,0x33,0x44; then start_sum with sum_len=4.
   - Required: four port-B writes, each 1 cycle after its strobe; then done after 6 busy cycles with sum=0x00AA.
3. Clear:
   - Stimulus: start_clear with fill_value=0xFF, then start_sum with sum_len=16.
   - Required: exactly 16 writes covering addresses 0..15; busy high for 17 cycles; subsequent sum=0x0FF0.
4. Checksum wrap (data_width_g=8, addr_width_g=10):
   - Stimulus: clear with 0xFF, then sum over sum_len=1024.
   - Required: sum=(1024×255) mod 65536=0xFC00.
5. Edge starts:
   - sum_len=0: required done 2 cycles after start, sum=0, ram_cs_b never high.
   - start_clear and start_sum in the same cycle: required clear runs, sum unchanged.
6. Contention:
   - Stimulus: dl_wr pulsed during CLEAR; start_sum pulsed while dl_active=1.
   - Required: dl_wait=1 throughout CLEAR and the strobe produces no write; start_sum is ignored and busy stays 0.
